clock_reset_sequencer: RTL and testbench
========================================

// Module: clock_reset_sequencer
// PURPOSE
//   Sits directly downstream of Gowin_PLL. Consumes the PLL output clock and lock flag.
//   Holds the system reset asserted until the PLL has been locked for HOLD_CYCLES clocks.
//   Then releases the reset and generates single-cycle clock-enable pulses (div-2, div-N).
//   Downstream logic therefore runs on one clock domain instead of on clkoutd.
// PARAMETERS
//   HOLD_CYCLES  1024  clocks of stable lock required before reset release (>=1)
//   HOLD_W       11    width of hold counter; 2^HOLD_W > HOLD_CYCLES
//   DIV_N        6     period of enable_divn in clocks (>=2); 6 gives 3.58 MHz from 21.48 MHz
//   DIV_W        3     width of divider counter; 2^DIV_W >= DIV_N
// PORTS
//   clk          in   1  PLL clkout; the only clock
//   n_reset      in   1  asynchronous, active-low reset
//   pll_lock     in   1  PLL lock flag, asynchronous to clk; tie 1 when using the PLL dummy
//   sys_n_reset  out  1  synchronous active-low system reset, registered
//   enable_div2  out  1  one-clock pulse every 2nd clock while running
//   enable_divn  out  1  one-clock pulse every DIV_N-th clock while running
//   seq_state    out  2  current state: 0 WAIT_LOCK, 1 HOLD, 2 RUN (3 unused)
// BEHAVIOUR
//   Reset (n_reset=0, async):
//     - state=WAIT_LOCK; sys_n_reset=0; enable_div2=0; enable_divn=0.
//     - All counters and synchroniser flops = 0.
//   Lock synchroniser:
//     - 2-flop chain. lock_s follows pll_lock after 2 rising edges.
//   WAIT_LOCK:
//     - sys_n_reset=0, enables=0.
//     - lock_s=1 -> HOLD, hold_cnt<=0.
//   HOLD:
//     - hold_cnt increments each clock.
//     - lock_s=0 -> WAIT_LOCK; this takes priority.
//     - hold_cnt==HOLD_CYCLES-1 -> RUN; on the same edge sys_n_reset<=1.
//     - Net latency from the first edge sampling pll_lock=1 to sys_n_reset=1 is HOLD_CYCLES+3 edges.
//   RUN:
//     - lock_s=0 -> WAIT_LOCK. On that edge sys_n_reset<=0 and both enables<=0.
//     - Any partial period is discarded.
//   Enable generation (registered; counters held at 0 outside RUN):
//     - Number RUN cycles k=0,1,2,... with k=0 the first cycle where sys_n_reset=1.
//     - enable_div2=1 for odd k.
//     - enable_divn=1 for k = DIV_N-1, 2*DIV_N-1, ...
//     - Divider counter wraps DIV_N-1 -> 0 with no gap.
//     - Both pulses are exactly one clock wide. Both coincide when k+1 is a multiple of lcm(2, DIV_N).
//   Boundaries:
//     - Lock glitch of 1 clk shorter than the synchroniser window may be missed (acceptable).
//     - A lock drop seen in HOLD restarts the full hold count.
//     - n_reset asserted mid-RUN clears all outputs immediately (async).
//     - On n_reset release, the sequence restarts from WAIT_LOCK.
//     - hold_cnt never wraps; comparison is exact equality.
//     - Parameter check at elaboration: DIV_N>=2, HOLD_CYCLES>=1, width constraints above; error otherwise.
// STRUCTURE
//   - Shared include: state encodings ST_WAIT_LOCK=2'd0, ST_HOLD=2'd1, ST_RUN=2'd2.
//     The same include is used by the bench.
//   - One sub-module: sync_2ff (clk, n_reset, d, q), a reusable 2-flop synchroniser with reset value 0.
//   - Remaining logic is flat:
//     - state register plus next-state logic
//     - hold counter
//     - div-2 toggle
//     - div-N counter
//     - output registers
// TESTING
//   1 Assert n_reset low mid-run: sys_n_reset, enable_div2, enable_divn go 0 immediately;
//     seq_state=0 with no clock edge.
//   2 HOLD_CYCLES=4, pll_lock=1 from edge 1: seq_state=1 after edge 3;
//     sys_n_reset=1 and seq_state=2 after edge 7, not earlier.
//   3 DIV_N=6 in RUN:
//     - enable_divn high at k=5,11,17 only.
//     - enable_div2 high at k=1,3,5,...
//     - Both high at k=5 and k=11.
//     - Count 600 clocks: exactly 100 divn pulses and 300 div2 pulses.
//   4 Drop pll_lock for 4 clocks during HOLD (hold_cnt=2): returns to WAIT_LOCK.
//     On re-lock, sys_n_reset rises a full HOLD_CYCLES+3 edges after re-lock.
//   5 Drop pll_lock in RUN at k=3: sys_n_reset=0 and enables=0 two edges after the drop is sampled.
//     On re-lock, after hold, enable_divn first fires at k=5 again.
//   6 pll_lock tied 1 (PLL dummy configuration) and n_reset toggled 3 times:
//     the identical release latency HOLD_CYCLES+3 is reproduced each time.

Source files
------------

// File: rtl/clock_reset_sequencer_pkg.sv
// rtl/clock_reset_sequencer_pkg.sv - state encodings shared by the sequencer and its bench
package clock_reset_sequencer_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_WAIT_LOCK = 2'd0;
  localparam seq_state_t ST_HOLD      = 2'd1;
  localparam seq_state_t ST_RUN       = 2'd2;

endpackage

// File: rtl/clock_reset_sequencer_if.sv
// rtl/clock_reset_sequencer_if.sv - lock input and reset/enable outputs of the sequencer
interface clock_reset_sequencer_if;
  import clock_reset_sequencer_pkg::*;

  logic       pll_lock;
  logic       sys_n_reset;
  logic       enable_div2;
  logic       enable_divn;
  seq_state_t seq_state;

  modport master (
    input  pll_lock,
    output sys_n_reset,
    output enable_div2,
    output enable_divn,
    output seq_state
  );

  modport slave (
    output pll_lock,
    input  sys_n_reset,
    input  enable_div2,
    input  enable_divn,
    input  seq_state
  );

endinterface

// File: rtl/clock_reset_sequencer_sync_2ff.sv
// rtl/clock_reset_sequencer_sync_2ff.sv - two-flop synchroniser, resets to 0
module sync_2ff (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_reset_sequencer.sv
// rtl/clock_reset_sequencer.sv - holds system reset until PLL lock is stable, then emits div-2/div-N enables
module clock_reset_sequencer
  import clock_reset_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int HOLD_W      = 11,
  parameter int DIV_N       = 6,
  parameter int DIV_W       = 3
) (
  input  logic                     clk,
  input  logic                     n_reset,
  clock_reset_sequencer_if.master  seq_if
);

  generate
    if (DIV_N < 2 || HOLD_CYCLES < 1 ||
        (1 << HOLD_W) <= HOLD_CYCLES || (1 << DIV_W) < DIV_N) begin : g_param_check
      $error("clock_reset_sequencer: illegal HOLD_CYCLES/HOLD_W/DIV_N/DIV_W");
    end
  endgenerate

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_N - 1);
  localparam logic [DIV_W-1:0]  DIV_PRE   = DIV_W'(DIV_N - 2);

  logic              lock_s;
  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              running;
  logic              sys_n_reset_q;
  logic              div2_q;
  logic              divn_q;

  sync_2ff u_lock_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (seq_if.pll_lock),
    .q       (lock_s)
  );

  // Lock loss wins over hold completion.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_LOCK: if (lock_s) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!lock_s)                    state_nxt = ST_WAIT_LOCK;
        else if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
      end
      ST_RUN:       if (!lock_s) state_nxt = ST_WAIT_LOCK;
      default:      state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // Enables only advance on cycles that are already in RUN and stay there.
  assign running = (state == ST_RUN) && (state_nxt == ST_RUN);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= ST_WAIT_LOCK;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      hold_cnt <= '0;
    end else if (state == ST_HOLD && state_nxt == ST_HOLD) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      div_cnt <= '0;
    end else if (running) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end else begin
      div_cnt <= '0;
    end
  end

  // divn fires one cycle after the counter reaches DIV_N-2, i.e. on k = DIV_N-1 mod DIV_N.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sys_n_reset_q <= 1'b0;
      div2_q        <= 1'b0;
      divn_q        <= 1'b0;
    end else begin
      sys_n_reset_q <= (state_nxt == ST_RUN);
      div2_q        <= running ? ~div2_q : 1'b0;
      divn_q        <= running && (div_cnt == DIV_PRE);
    end
  end

  assign seq_if.sys_n_reset = sys_n_reset_q;
  assign seq_if.enable_div2 = div2_q;
  assign seq_if.enable_divn = divn_q;
  assign seq_if.seq_state   = state;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// tb/tb_clock_reset_sequencer.sv - scoreboard bench for clock_reset_sequencer
module tb_clock_reset_sequencer;
  import clock_reset_sequencer_pkg::*;

  localparam int HC = 4;
  localparam int DN = 6;

  typedef struct packed {
    logic       rst;
    logic       d2;
    logic       dn;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic n_reset;

  clock_reset_sequencer_if sif ();

  clock_reset_sequencer #(
    .HOLD_CYCLES (HC),
    .HOLD_W      (3),
    .DIV_N       (DN),
    .DIV_W       (3)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .seq_if  (sif)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  // Consecutive edges that sampled pll_lock=1, as of one and two edges ago.
  int   ones_m1  = 0;
  int   ones_m2  = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Outputs after an edge depend on how long lock had been sampled high two edges earlier.
  function automatic exp_t model(input int ones);
    exp_t x;
    int   k;
    x = '0;
    if (ones >= HC + 1) begin
      k    = ones - (HC + 1);
      x.rst = 1'b1;
      x.d2  = k[0];
      x.dn  = ((k + 1) % DN) == 0;
      x.st  = ST_RUN;
    end else if (ones >= 1) begin
      x.st = ST_HOLD;
    end else begin
      x.st = ST_WAIT_LOCK;
    end
    return x;
  endfunction

  task automatic step(input logic lock);
    exp_t e;
    int   ones_new;
    sif.pll_lock = lock;
    @(posedge clk);
    sb_q.push_back(model(ones_m2));
    ones_new = lock ? ones_m1 + 1 : 0;
    ones_m2  = ones_m1;
    ones_m1  = ones_new;
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_eq("sys_n_reset", int'(sif.sys_n_reset), int'(e.rst));
      check_eq("enable_div2", int'(sif.enable_div2), int'(e.d2));
      check_eq("enable_divn", int'(sif.enable_divn), int'(e.dn));
      check_eq("seq_state",   int'(sif.seq_state),   int'(e.st));
    end
  endtask

  task automatic do_reset();
    #2 n_reset = 1'b0;
    #1;
    check_eq("async_sys_n_reset", int'(sif.sys_n_reset), 0);
    check_eq("async_enable_div2", int'(sif.enable_div2), 0);
    check_eq("async_enable_divn", int'(sif.enable_divn), 0);
    check_eq("async_seq_state",   int'(sif.seq_state),   int'(ST_WAIT_LOCK));
    @(posedge clk);
    #1;
    check_eq("held_sys_n_reset", int'(sif.sys_n_reset), 0);
    check_eq("held_seq_state",   int'(sif.seq_state),   int'(ST_WAIT_LOCK));
    ones_m1 = 0;
    ones_m2 = 0;
    sb_q.delete();
    #2 n_reset = 1'b1;
  endtask

  // Counts edges with pll_lock=1 until sys_n_reset rises; the first such edge counts as 1.
  task automatic measure_release(input string tag);
    int lat;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b1);
      lat++;
      if (sif.sys_n_reset) break;
    end
    check_eq(tag, lat, HC + 3);
  endtask

  initial begin
    int n_d2;
    int n_dn;
    int first_dn;
    n_reset      = 1'b1;
    sif.pll_lock = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Lock from edge 1: HOLD after edge 3, RUN after edge 7.
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check_eq("hold_after_edge3", int'(sif.seq_state), int'(ST_HOLD));
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check_eq("no_early_release", int'(sif.sys_n_reset), 0);
    step(1'b1);
    check_eq("release_edge7", int'(sif.sys_n_reset), 1);

    // 600 RUN cycles starting at k=0.
    n_d2 = int'(sif.enable_div2);
    n_dn = int'(sif.enable_divn);
    for (int k = 1; k < 600; k++) begin
      step(1'b1);
      n_d2 += int'(sif.enable_div2);
      n_dn += int'(sif.enable_divn);
    end
    check_eq("div2_pulses_600", n_d2, 300);
    check_eq("divn_pulses_600", n_dn, 100);

    // Asynchronous reset in the middle of RUN.
    do_reset();

    // Lock drop seen while hold_cnt=2 restarts the hold.
    step(1'b1);
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    check_eq("hold_drop_wait", int'(sif.seq_state), int'(ST_WAIT_LOCK));
    measure_release("relock_latency");

    // Lock drop in RUN at k=3.
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check_eq("run_drop_still_up", int'(sif.sys_n_reset), 1);
    step(1'b0);
    check_eq("run_drop_reset", int'(sif.sys_n_reset), 0);
    check_eq("run_drop_div2",  int'(sif.enable_div2), 0);
    check_eq("run_drop_divn",  int'(sif.enable_divn), 0);
    step(1'b0);
    measure_release("run_relock_latency");
    first_dn = -1;
    for (int k = 1; k < 20; k++) begin
      step(1'b1);
      if (sif.enable_divn) begin
        first_dn = k;
        break;
      end
    end
    check_eq("first_divn_k", first_dn, DN - 1);

    // Lock tied high across repeated resets.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      measure_release("tied_lock_latency");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
